deserializador_param: RTL and testbench

DESERIALIZADOR_PARAM -- requirements
Module: deserializador_param

---
 rtl/deserializador_param.sv | 108 ++++++++++
 tb/tb_deserializador_param.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/deserializador_param.sv
// Serial-to-parallel deserializer: WIDTH-bit words assembled from a bit stream, queued DEPTH deep.
// Optional macro DESER_OVERFLOW_CNT_EN adds overflow_cnt, a saturating count of bits dropped while stalled.
module deserializador_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_100KHz,
  input  logic             reset,
  input  logic             data_in,
  input  logic             write_in,
  input  logic             ack_in,
  output logic             status_out,
  output logic [WIDTH-1:0] data_out,
  output logic             data_ready
`ifdef DESER_OVERFLOW_CNT_EN
  ,
  output logic [7:0]       overflow_cnt
`endif
);
  localparam int CW = $clog2(WIDTH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);

  typedef enum logic {ACCEPT = 1'b0, STALL = 1'b1} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] sr, sr_nxt;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [OW-1:0]    occ, occ_nxt;
  logic             accept, push, pop;
  logic [WIDTH-1:0] head_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk_100KHz or posedge reset) begin
    if (reset) state <= ACCEPT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    status_out = 1'b0;
    case (state)
      ACCEPT: if (push && !pop && occ == OW'(DEPTH - 1)) state_nxt = STALL;
      STALL: begin
        status_out = 1'b1;
        if (pop) state_nxt = ACCEPT;
      end
      default: state_nxt = ACCEPT;
    endcase
  end

  // Outputs are registered from post-edge queue state, so the head word is
  // looked up through the next read pointer; a word pushed into an empty slot
  // that becomes the head bypasses the memory.
  always_comb begin
    accept     = write_in && (state == ACCEPT);
    push       = accept && (bit_cnt == CW'(WIDTH - 1));
    pop        = ack_in && data_ready;
    sr_nxt     = MSB_FIRST ? {sr[WIDTH-2:0], data_in} : {data_in, sr[WIDTH-1:1]};
    rd_ptr_nxt = pop ? ptr_inc(rd_ptr) : rd_ptr;
    occ_nxt    = occ + OW'(push) - OW'(pop);
    head_nxt   = '0;
    if (occ_nxt != '0)
      head_nxt = (push && rd_ptr_nxt == wr_ptr) ? sr_nxt : mem[rd_ptr_nxt];
  end

  always_ff @(posedge clk_100KHz or posedge reset) begin
    if (reset) begin
      sr         <= '0;
      bit_cnt    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      data_ready <= 1'b0;
      data_out   <= '0;
    end else begin
      if (accept) begin
        sr      <= sr_nxt;
        bit_cnt <= push ? '0 : bit_cnt + CW'(1);
      end
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      rd_ptr     <= rd_ptr_nxt;
      occ        <= occ_nxt;
      data_ready <= (occ_nxt != '0);
      data_out   <= head_nxt;
    end
  end

  always_ff @(posedge clk_100KHz) begin
    if (push) mem[wr_ptr] <= sr_nxt;
  end

`ifdef DESER_OVERFLOW_CNT_EN
  always_ff @(posedge clk_100KHz or posedge reset) begin
    if (reset)
      overflow_cnt <= '0;
    else if (write_in && status_out && overflow_cnt != 8'hFF)
      overflow_cnt <= overflow_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_deserializador_param.sv
// Bench for deserializador_param: directed scenarios plus a randomized run against a queue-based model.
module tb_deserializador_param;
  logic clk_100KHz;
  logic reset;
  logic d0, w0, a0, st0, rdy0;
  logic [7:0] q0;
  logic d1, w1, a1, st1, rdy1;
  logic [7:0] q1;
  logic d2, w2, a2, st2, rdy2;
  logic [11:0] q2;
`ifdef DESER_OVERFLOW_CNT_EN
  logic [7:0] ovf0, ovf1, ovf2;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // reference model for the default instance
  logic [7:0] m_q[$];
  bit         m_bits[$];
  int         m_ovf;

  initial clk_100KHz = 1'b0;
  always #5 clk_100KHz = ~clk_100KHz;

  deserializador_param dut (
    .clk_100KHz(clk_100KHz), .reset(reset), .data_in(d0), .write_in(w0), .ack_in(a0),
    .status_out(st0), .data_out(q0), .data_ready(rdy0)
`ifdef DESER_OVERFLOW_CNT_EN
    , .overflow_cnt(ovf0)
`endif
  );

  deserializador_param #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk_100KHz(clk_100KHz), .reset(reset), .data_in(d1), .write_in(w1), .ack_in(a1),
    .status_out(st1), .data_out(q1), .data_ready(rdy1)
`ifdef DESER_OVERFLOW_CNT_EN
    , .overflow_cnt(ovf1)
`endif
  );

  deserializador_param #(.WIDTH(12), .DEPTH(2), .MSB_FIRST(1'b1)) dut_w12 (
    .clk_100KHz(clk_100KHz), .reset(reset), .data_in(d2), .write_in(w2), .ack_in(a2),
    .status_out(st2), .data_out(q2), .data_ready(rdy2)
`ifdef DESER_OVERFLOW_CNT_EN
    , .overflow_cnt(ovf2)
`endif
  );

  function automatic logic [7:0] m_head();
    return (m_q.size() > 0) ? m_q[0] : 8'h00;
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_bits.delete();
    m_ovf = 0;
  endtask

  // One clock on the default instance; the model applies the same edge first.
  task automatic step(input logic d, input logic w, input logic a);
    logic [7:0] word;
    bit full;
    full = (m_q.size() == 4);
    d0 = d; w0 = w; a0 = a;
    if (a && m_q.size() > 0) m_q.delete(0);
    if (w && !full) begin
      m_bits.push_back(d);
      if (m_bits.size() == 8) begin
        word = '0;
        for (int i = 0; i < 8; i++) word[7-i] = m_bits[i];
        m_q.push_back(word);
        m_bits.delete();
      end
    end
    if (w && full && m_ovf < 255) m_ovf++;
    @(posedge clk_100KHz); #1;
    d0 = 1'b0; w0 = 1'b0; a0 = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] wd);
    for (int i = 7; i >= 0; i--) step(wd[i], 1'b1, 1'b0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_clear();
    @(posedge clk_100KHz); #1;
  endtask

  task automatic test_reset();
    d0 = 0; w0 = 0; a0 = 0; d1 = 0; w1 = 0; a1 = 0; d2 = 0; w2 = 0; a2 = 0;
    reset = 1'b1;
    model_clear();
    #3;
    n_cmp++; if ({st0, rdy0, q0} !== 10'd0) begin n_err++; $display("FAIL reset_dut got=%b exp=0", {st0, rdy0, q0}); end
    n_cmp++; if ({st1, rdy1, q1} !== 10'd0) begin n_err++; $display("FAIL reset_lsb got=%b exp=0", {st1, rdy1, q1}); end
    n_cmp++; if ({st2, rdy2, q2} !== 14'd0) begin n_err++; $display("FAIL reset_w12 got=%b exp=0", {st2, rdy2, q2}); end
`ifdef DESER_OVERFLOW_CNT_EN
    n_cmp++; if (ovf0 !== 8'd0) begin n_err++; $display("FAIL reset_ovf got=%0d exp=0", ovf0); end
`endif
    @(posedge clk_100KHz); #1;
    reset = 1'b0;
    @(posedge clk_100KHz); #1;
  endtask

  task automatic test_basic();
    logic [7:0] pat;
    pat = 8'b1011_0010;
    for (int i = 7; i >= 0; i--) begin
      step(pat[i], 1'b1, 1'b0);
      if (i == 1) begin
        n_cmp++; if (rdy0 !== 1'b0) begin n_err++; $display("FAIL basic_early_ready got=%b exp=0", rdy0); end
      end
    end
    n_cmp++; if (rdy0 !== 1'b1) begin n_err++; $display("FAIL basic_ready got=%b exp=1", rdy0); end
    n_cmp++; if (q0 !== 8'hB2) begin n_err++; $display("FAIL basic_data got=%h exp=b2", q0); end
    step(1'b0, 1'b0, 1'b1);
    n_cmp++; if ({rdy0, q0} !== 9'h000) begin n_err++; $display("FAIL basic_ack got=%b/%h exp=0/00", rdy0, q0); end
    step(1'b0, 1'b0, 1'b1);
    n_cmp++; if (rdy0 !== 1'b0) begin n_err++; $display("FAIL basic_ack_empty got=%b exp=0", rdy0); end
  endtask

  task automatic test_lsb_first();
    logic [7:0] pat;
    pat = 8'b1011_0010;
    for (int i = 7; i >= 0; i--) begin
      d1 = pat[i]; w1 = 1'b1;
      @(posedge clk_100KHz); #1;
    end
    w1 = 1'b0; d1 = 1'b0;
    n_cmp++; if ({rdy1, q1} !== {1'b1, 8'h4D}) begin n_err++; $display("FAIL lsb_data got=%b/%h exp=1/4d", rdy1, q1); end
    a1 = 1'b1;
    @(posedge clk_100KHz); #1;
    a1 = 1'b0;
    n_cmp++; if ({rdy1, q1} !== 9'h000) begin n_err++; $display("FAIL lsb_ack got=%b/%h exp=0/00", rdy1, q1); end
  endtask

  task automatic test_full();
    logic [7:0] exp_seq [4];
    exp_seq = '{8'h22, 8'h33, 8'h44, 8'h00};
    apply_reset();
    send_word(8'h11); send_word(8'h22); send_word(8'h33);
    n_cmp++; if (st0 !== 1'b0) begin n_err++; $display("FAIL full_three got=%b exp=0", st0); end
    send_word(8'h44);
    n_cmp++; if (st0 !== 1'b1) begin n_err++; $display("FAIL full_status got=%b exp=1", st0); end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    n_cmp++; if ({st0, rdy0, q0} !== {2'b11, 8'h11}) begin n_err++; $display("FAIL full_hold got=%b/%b/%h exp=1/1/11", st0, rdy0, q0); end
`ifdef DESER_OVERFLOW_CNT_EN
    n_cmp++; if (ovf0 !== 8'd3) begin n_err++; $display("FAIL full_ovf got=%0d exp=3", ovf0); end
`endif
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1);
      n_cmp++; if (q0 !== exp_seq[i]) begin n_err++; $display("FAIL full_drain%0d got=%h exp=%h", i, q0, exp_seq[i]); end
      n_cmp++; if (st0 !== 1'b0) begin n_err++; $display("FAIL full_unstall%0d got=%b exp=0", i, st0); end
    end
    send_word(8'h5A);
    n_cmp++; if (q0 !== 8'h5A) begin n_err++; $display("FAIL full_resume got=%h exp=5a", q0); end
    step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_stall_ack();
    apply_reset();
    send_word(8'hA1); send_word(8'hA2); send_word(8'hA3); send_word(8'hA4);
    step(1'b1, 1'b1, 1'b1);
    n_cmp++; if ({st0, q0} !== {1'b0, 8'hA2}) begin n_err++; $display("FAIL stall_ack got=%b/%h exp=0/a2", st0, q0); end
    send_word(8'h66);
    n_cmp++; if (st0 !== 1'b1) begin n_err++; $display("FAIL stall_refill got=%b exp=1", st0); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (q0 !== m_head()) begin n_err++; $display("FAIL stall_drain%0d got=%h exp=%h", i, q0, m_head()); end
      step(1'b0, 1'b0, 1'b1);
    end
    n_cmp++; if (rdy0 !== 1'b0) begin n_err++; $display("FAIL stall_empty got=%b exp=0", rdy0); end
  endtask

  task automatic test_simul_push_pop();
    logic [7:0] wd;
    wd = 8'h55;
    send_word(8'hA1); send_word(8'hA2);
    for (int i = 7; i >= 1; i--) step(wd[i], 1'b1, 1'b0);
    step(wd[0], 1'b1, 1'b1);
    n_cmp++; if ({st0, rdy0, q0} !== {2'b01, 8'hA2}) begin n_err++; $display("FAIL simul_head got=%b/%b/%h exp=0/1/a2", st0, rdy0, q0); end
    step(1'b0, 1'b0, 1'b1);
    n_cmp++; if (q0 !== 8'h55) begin n_err++; $display("FAIL simul_last got=%h exp=55", q0); end
    step(1'b0, 1'b0, 1'b1);
    n_cmp++; if (rdy0 !== 1'b0) begin n_err++; $display("FAIL simul_empty got=%b exp=0", rdy0); end
  endtask

  task automatic test_reset_mid();
    send_word(8'hC3);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    n_cmp++; if ({st0, rdy0, q0} !== 10'd0) begin n_err++; $display("FAIL midreset_async got=%b exp=0", {st0, rdy0, q0}); end
    #2;
    reset = 1'b0;
    model_clear();
    @(posedge clk_100KHz); #1;
    send_word(8'h3C);
    n_cmp++; if ({rdy0, q0} !== {1'b1, 8'h3C}) begin n_err++; $display("FAIL midreset_word got=%b/%h exp=1/3c", rdy0, q0); end
    step(1'b0, 1'b0, 1'b1);
    n_cmp++; if (rdy0 !== 1'b0) begin n_err++; $display("FAIL midreset_single got=%b exp=0", rdy0); end
  endtask

  task automatic test_width12();
    logic [11:0] pat;
    pat = 12'hA5C;
    for (int i = 11; i >= 0; i--) begin
      d2 = pat[i]; w2 = 1'b1;
      @(posedge clk_100KHz); #1;
      if (i == 1) begin
        n_cmp++; if (rdy2 !== 1'b0) begin n_err++; $display("FAIL w12_early got=%b exp=0", rdy2); end
      end
    end
    n_cmp++; if ({rdy2, q2} !== {1'b1, 12'hA5C}) begin n_err++; $display("FAIL w12_data got=%b/%h exp=1/a5c", rdy2, q2); end
    pat = 12'h123;
    for (int i = 11; i >= 0; i--) begin
      d2 = pat[i]; w2 = 1'b1;
      @(posedge clk_100KHz); #1;
    end
    w2 = 1'b0;
    n_cmp++; if ({st2, q2} !== {1'b1, 12'hA5C}) begin n_err++; $display("FAIL w12_full got=%b/%h exp=1/a5c", st2, q2); end
    a2 = 1'b1;
    @(posedge clk_100KHz); #1;
    a2 = 1'b0;
    n_cmp++; if ({st2, q2} !== {1'b0, 12'h123}) begin n_err++; $display("FAIL w12_second got=%b/%h exp=0/123", st2, q2); end
  endtask

  task automatic test_random();
    logic d, w, a;
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      d = 1'($urandom_range(0, 1));
      w = ($urandom_range(0, 9) < 7);
      a = ($urandom_range(0, 9) < ((c / 300) % 2 == 0 ? 1 : 4));
      step(d, w, a);
      n_cmp++;
      if ({st0, rdy0, q0} !== {(m_q.size() == 4), (m_q.size() > 0), m_head()}) begin
        n_err++;
        $display("FAIL random_c%0d got=%b/%b/%h exp=%b/%b/%h", c, st0, rdy0, q0,
                 (m_q.size() == 4), (m_q.size() > 0), m_head());
      end
`ifdef DESER_OVERFLOW_CNT_EN
      n_cmp++; if (ovf0 !== 8'(m_ovf)) begin n_err++; $display("FAIL random_ovf_c%0d got=%0d exp=%0d", c, ovf0, m_ovf); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lsb_first();
    test_full();
    test_stall_ack();
    test_simul_push_pop();
    test_reset_mid();
    test_width12();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
